// File: rtl/si_pkg.sv
// si_pkg: shared FSM state type and signed range helpers for the si_* blocks.
package si_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic logic [63:0] smax(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
  // Magnitude of the most-negative value; its low n bits are also its bit pattern.
  function automatic logic [63:0] smin_mag(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/si_sat_trunc.sv
// si_sat_trunc: rescales a sign-magnitude product to N bits with saturate or wrap on overflow.
module si_sat_trunc import si_pkg::*; #(
  parameter int N = 8,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input  logic [2*N-1:0] mag_i,
  input  logic           neg_i,
  output logic [N-1:0]   res_o,
  output logic           ovf_o
);
  localparam int W = 2 * N;
  logic [W-1:0] m, lim, r;
  always_comb begin
    m = mag_i >> FRAC;
    lim = neg_i ? W'(smin_mag(N)) : W'(smax(N));
    r = neg_i ? -m : m;
    ovf_o = m > lim;
    res_o = (ovf_o && SAT != 0) ? (neg_i ? N'(smin_mag(N)) : N'(smax(N))) : r[N-1:0];
  end
endmodule

// File: rtl/si_mpy_seq.sv
// si_mpy_seq: sequential signed fixed-point multiplier, radix-2 shift-add over N cycles.
module si_mpy_seq import si_pkg::*; #(
  parameter int N = 8,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] A_MPY_B,
  output logic         OVF
);
  localparam int CW = $clog2(N);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_w;
  logic [2*N-1:0] acc_q, acc_d;
  logic neg_q, neg_d, ovf_q, ovf_d, ovf_w, last;
  // Fed from acc_d so the final partial product lands in the result register on the same edge.
  si_sat_trunc #(.N(N), .FRAC(FRAC), .SAT(SAT)) u_sat (
    .mag_i(acc_d), .neg_i(neg_q), .res_o(res_w), .ovf_o(ovf_w)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    neg_d = neg_q;
    res_d = res_q;
    ovf_d = ovf_q;
    last = cnt_q == CW'(N - 1);
    if (state_q == IDLE && IN_VALID) begin
      state_d = CALC;
      neg_d = A[N-1] ^ B[N-1];
      a_d = A[N-1] ? -A : A;
      b_d = B[N-1] ? -B : B;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      acc_d = acc_q + (b_q[0] ? ({{N{1'b0}}, a_q} << cnt_q) : '0);
      b_d = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : CALC;
      res_d = last ? res_w : res_q;
      ovf_d = last ? ovf_w : ovf_q;
    end else if (state_q == DONE && OUT_READY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end
  assign IN_READY = state_q == IDLE;
  assign OUT_VALID = state_q == DONE;
  assign A_MPY_B = res_q;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_si_mpy_seq.sv
// tb_si_mpy_seq: three configurations (Q8.0 sat, Q8.0 wrap, Q4.4 sat) driven in lockstep against an integer model.
module tb_si_mpy_seq;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] a, b, res0, res1, res2;
  logic [2:0] in_ready, out_valid, ovf;
  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  typedef struct packed {logic [2:0] o; logic [23:0] r;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  si_mpy_seq #(.N(8), .FRAC(0), .SAT(1)) u0 (.CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[0]),
    .A(a), .B(b), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready), .A_MPY_B(res0), .OVF(ovf[0]));
  si_mpy_seq #(.N(8), .FRAC(0), .SAT(0)) u1 (.CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[1]),
    .A(a), .B(b), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready), .A_MPY_B(res1), .OVF(ovf[1]));
  si_mpy_seq #(.N(8), .FRAC(4), .SAT(1)) u2 (.CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[2]),
    .A(a), .B(b), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready), .A_MPY_B(res2), .OVF(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] model(input int av, input int bv, input int frac, input bit sat);
    int q;
    logic [7:0] r;
    logic o;
    q = (av * bv) / (1 << frac);
    o = q > 127 || q < -128;
    r = q[7:0];
    if (o && sat) r = q > 0 ? 8'h7f : 8'h80;
    return {o, r};
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
    exp_t e;
    logic [8:0] m0, m1, m2;
    int n;
    n = 0;
    while (!in_ready[0] && n < 50) begin @(negedge clk); n++; end
    m0 = model(int'($signed(av)), int'($signed(bv)), 0, 1'b1);
    m1 = model(int'($signed(av)), int'($signed(bv)), 0, 1'b0);
    m2 = model(int'($signed(av)), int'($signed(bv)), 4, 1'b1);
    e.o = {m2[8], m1[8], m0[8]};
    e.r = {m2[7:0], m1[7:0], m0[7:0]};
    sb.push_back(e);
    a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 40) begin @(negedge clk); n++; end
    chk($sformatf("latency %h*%h", av, bv), n, 8);
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", {29'd0, in_ready}, 0);
      chk("hold_res", {res2, res1, res0}, e.r);
      chk("hold_ovf", {29'd0, ovf}, {29'd0, e.o});
      @(negedge clk);
    end
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_valid", {29'd0, out_valid}, 7);
      chk($sformatf("res_q8_sat %h*%h", av, bv), res0, e.r[7:0]);
      chk($sformatf("res_q8_wrap %h*%h", av, bv), res1, e.r[15:8]);
      chk($sformatf("res_q44 %h*%h", av, bv), res2, e.r[23:16]);
      chk($sformatf("ovf %h*%h", av, bv), {29'd0, ovf}, {29'd0, e.o});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_xfer_idle", {29'd0, in_ready, out_valid}, 6'b111000);
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready_valid", {29'd0, in_ready, out_valid}, 6'b111000);
    chk("reset_res", {res2, res1, res0}, 0);
    chk("reset_ovf", {29'd0, ovf}, 0);
    run_op(8'd5, 8'hFD, 0);
    run_op(8'd20, 8'd20, 5);
    run_op(8'h80, 8'hFF, 0);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h18, 8'h28, 0);
    run_op(8'hE8, 8'h11, 0);
    run_op(8'h00, 8'h80, 0);
    run_op(8'h80, 8'h80, 0);
    a = 8'd3; b = 8'd4; in_valid = 1'b1; out_ready = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
    end
    in_valid = 1'b0;
    chk("b2b_interval", t1 - t0, 10);
    a = 8'd9; b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready_valid", {29'd0, in_ready, out_valid}, 6'b111000);
    chk("rst_mid_res", {res2, res1, res0}, 0);
    repeat (12) begin
      @(negedge clk);
      chk("rst_no_valid", {29'd0, out_valid}, 0);
    end
    run_op(8'd7, 8'd7, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
